// File: rtl/spi_tx_master_if.sv
// Request handshake and serial pins of spi_tx_master, grouped as one bundle.
// master: the SPI transmitter side; slave: the requesting control logic.
interface spi_tx_master_if #(
    parameter int WORD_W = 14,
    parameter int NUM_CS = 1
);
    localparam int SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic [WORD_W-1:0] i_TX_Data;
    logic [SEL_W-1:0]  i_TX_CS_Sel;
    logic              i_TX_DV;
    logic              o_TX_Ready;
    logic              o_TX_Done;
    logic              o_SPI_Clk;
    logic              o_SPI_MOSI;
    logic [NUM_CS-1:0] o_SPI_CS_n;

    modport master (
        input  i_TX_Data, i_TX_CS_Sel, i_TX_DV,
        output o_TX_Ready, o_TX_Done, o_SPI_Clk, o_SPI_MOSI, o_SPI_CS_n
    );

    modport slave (
        output i_TX_Data, i_TX_CS_Sel, i_TX_DV,
        input  o_TX_Ready, o_TX_Done, o_SPI_Clk, o_SPI_MOSI, o_SPI_CS_n
    );
endinterface

// File: rtl/spi_tx_master.sv
// MOSI-only SPI master, modes 0-3; one frame takes (2W+1)H+GAP+1 cycles from accept to next accept.
// Backpressure: o_TX_Ready low from accept until the CS gap expires; requests while busy are dropped.
module spi_tx_master #(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int WORD_W            = 14,
    parameter int NUM_CS            = 1,
    parameter int CS_GAP_CLKS       = 2
) (
    input logic           i_Clk,
    input logic           i_Rst_L,
    spi_tx_master_if.master bus
);
    localparam logic CPOL  = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic CPHA  = (SPI_MODE == 1) || (SPI_MODE == 3);
    localparam int   SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int   SELX  = SEL_W + 1;
    localparam int   HCW   = $clog2(CLKS_PER_HALF_BIT) + 1;
    localparam int   ECW   = $clog2(2 * WORD_W + 1);
    localparam int   GCW   = (CS_GAP_CLKS > 1) ? $clog2(CS_GAP_CLKS) : 1;

    localparam logic [HCW-1:0]  HALF_LAST = HCW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [ECW-1:0]  EDGE_LAST = ECW'(2 * WORD_W);
    localparam logic [GCW-1:0]  GAP_LAST  = (CS_GAP_CLKS > 0) ? GCW'(CS_GAP_CLKS - 1) : '0;
    localparam logic [SELX-1:0] NCS_V     = SELX'(NUM_CS);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t            state;
    logic [HCW-1:0]    half_cnt;
    logic [ECW-1:0]    edge_cnt;
    logic [GCW-1:0]    gap_cnt;
    logic [WORD_W-1:0] shreg;
    logic              ready_q;
    logic              done_q;
    logic              sck_q;
    logic              mosi_q;
    logic [NUM_CS-1:0] cs_n_q;

    logic [SEL_W-1:0]  sel_eff;
    logic [NUM_CS-1:0] cs_sel_n;
    logic [ECW-1:0]    edge_nxt;
    logic              half_wrap;
    logic              advance;

    always_comb begin
        sel_eff   = ({1'b0, bus.i_TX_CS_Sel} < NCS_V) ? bus.i_TX_CS_Sel : '0;
        cs_sel_n  = ~(NUM_CS'(1) << sel_eff);
        edge_nxt  = edge_cnt + ECW'(1);
        half_wrap = (half_cnt == HALF_LAST);
        // CPHA=1 moves MOSI on leading (odd) edges; CPHA=0 on trailing edges except the last.
        advance   = edge_nxt[0] ? CPHA : (!CPHA && (edge_nxt != EDGE_LAST));
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state    <= IDLE;
            half_cnt <= '0;
            edge_cnt <= '0;
            gap_cnt  <= '0;
            shreg    <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            sck_q    <= CPOL;
            mosi_q   <= 1'b0;
            cs_n_q   <= '1;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_TX_DV && ready_q) begin
                        ready_q  <= 1'b0;
                        cs_n_q   <= cs_sel_n;
                        // CPHA=0 presents the MSB now, so the register holds the remaining bits.
                        shreg    <= CPHA ? bus.i_TX_Data : (bus.i_TX_Data << 1);
                        mosi_q   <= CPHA ? 1'b0 : bus.i_TX_Data[WORD_W-1];
                        half_cnt <= '0;
                        edge_cnt <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP, SHIFT: begin
                    if (half_wrap) begin
                        half_cnt <= '0;
                        edge_cnt <= edge_nxt;
                        sck_q    <= ~sck_q;
                        if (advance) begin
                            mosi_q <= shreg[WORD_W-1];
                            shreg  <= shreg << 1;
                        end
                        state <= (edge_nxt == EDGE_LAST) ? HOLD : SHIFT;
                    end else begin
                        half_cnt <= half_cnt + HCW'(1);
                    end
                end
                HOLD: begin
                    if (half_wrap) begin
                        half_cnt <= '0;
                        cs_n_q   <= '1;
                        mosi_q   <= 1'b0;
                        done_q   <= 1'b1;
                        gap_cnt  <= '0;
                        if (CS_GAP_CLKS == 0) begin
                            ready_q <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        half_cnt <= half_cnt + HCW'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GCW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_TX_Ready = ready_q;
    assign bus.o_TX_Done  = done_q;
    assign bus.o_SPI_Clk  = sck_q;
    assign bus.o_SPI_MOSI = mosi_q;
    assign bus.o_SPI_CS_n = cs_n_q;
endmodule

// File: tb/tb_spi_tx_master.sv
// Six spi_tx_master configurations checked every cycle against a frame-timeline model,
// plus directed literal checks on timing, chip selects and captured words.
module tb_spi_tx_master;
    localparam int ND = 6;

    logic clk;
    logic rst_n;

    logic [ND-1:0]        drv_dv;
    logic [ND-1:0][31:0]  drv_dat;
    logic [ND-1:0][2:0]   drv_sel;
    logic [ND-1:0]        obs_rdy, obs_done, obs_sck, obs_mosi;
    logic [ND-1:0][7:0]   obs_cs;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int cur   = 0;

    // configs: 0 A mode0, 1 B mode3 H1, 2 C four CS, 3 D1 mode1, 4 D2 mode2, 5 E gap0 five CS
    function automatic int cfg_mode(input int g);
        case (g) 1: return 3; 3: return 1; 4: return 2; default: return 0; endcase
    endfunction
    function automatic int cfg_h(input int g);
        case (g) 1: return 1; 3: return 3; 4: return 3; 5: return 1; default: return 2; endcase
    endfunction
    function automatic int cfg_w(input int g);
        case (g) 3: return 8; 4: return 8; 5: return 4; default: return 14; endcase
    endfunction
    function automatic int cfg_ncs(input int g);
        case (g) 2: return 4; 5: return 5; default: return 1; endcase
    endfunction
    function automatic int cfg_gap(input int g);
        case (g) 5: return 0; default: return 2; endcase
    endfunction

    for (genvar g = 0; g < ND; g++) begin : gen_dut
        localparam int W   = cfg_w(g);
        localparam int NCS = cfg_ncs(g);
        localparam int SW  = (NCS > 1) ? $clog2(NCS) : 1;

        spi_tx_master_if #(.WORD_W(W), .NUM_CS(NCS)) bus ();

        spi_tx_master #(
            .SPI_MODE(cfg_mode(g)), .CLKS_PER_HALF_BIT(cfg_h(g)), .WORD_W(W),
            .NUM_CS(NCS), .CS_GAP_CLKS(cfg_gap(g))
        ) dut (
            .i_Clk(clk), .i_Rst_L(rst_n), .bus(bus)
        );

        assign bus.i_TX_Data   = drv_dat[g][W-1:0];
        assign bus.i_TX_CS_Sel = drv_sel[g][SW-1:0];
        assign bus.i_TX_DV     = drv_dv[g];
        assign obs_rdy[g]      = bus.o_TX_Ready;
        assign obs_done[g]     = bus.o_TX_Done;
        assign obs_sck[g]      = bus.o_SPI_Clk;
        assign obs_mosi[g]     = bus.o_SPI_MOSI;
        assign obs_cs[g]       = {{(8-NCS){1'b1}}, bus.o_SPI_CS_n};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: per DUT, when the current frame was accepted and what it carries.
    bit          busy  [ND];
    int          start [ND];
    logic [31:0] mdat  [ND];
    int          msel  [ND];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < ND; g++) busy[g] = 1'b0;
        end else begin
            cyc++;
            for (int g = 0; g < ND; g++) begin
                bit rdy;
                rdy = !busy[g] || ((cyc - start[g]) >= 1 + (2*cfg_w(g)+1)*cfg_h(g) + cfg_gap(g));
                if (drv_dv[g] && rdy) begin
                    busy[g]  = 1'b1;
                    start[g] = cyc;
                    mdat[g]  = drv_dat[g];
                    msel[g]  = (int'(drv_sel[g]) >= cfg_ncs(g)) ? 0 : int'(drv_sel[g]);
                end
            end
        end
    end

    // Expected {ready, done, sck, mosi, cs_n[7:0]} in frame cycle n (n=1 is the cycle after accept).
    function automatic logic [11:0] model_out(input int g, input bit act, input int n,
                                              input logic [31:0] d, input int sel);
        int h, w, fl, e, idx;
        bit cpol, cpha;
        logic rdy, dn, sck, mo;
        logic [7:0] cs;
        h = cfg_h(g); w = cfg_w(g);
        cpol = (cfg_mode(g) >= 2);
        cpha = (cfg_mode(g) % 2) == 1;
        fl = (2*w + 1) * h;
        rdy = 1'b1; dn = 1'b0; sck = cpol; mo = 1'b0; cs = 8'hFF;
        if (act) begin
            rdy = (n >= fl + 1 + cfg_gap(g));
            dn  = (n == fl + 1);
            e   = (n - 1) / h;
            if (e > 2*w) e = 2*w;
            sck = cpol ^ e[0];
            if (n <= fl) begin
                cs[sel] = 1'b0;
                if (!cpha) idx = w - 1 - (((e/2) < (w-1)) ? (e/2) : (w-1));
                else       idx = (e == 0) ? -1 : w - (e+1)/2;
                mo = (idx < 0) ? 1'b0 : d[idx];
            end
        end
        return {rdy, dn, sck, mo, cs};
    endfunction

    // Per-cycle compare plus a slave-side capture of MOSI on the sampling edge.
    logic [31:0] cap [ND];
    int          capn[ND];
    logic [31:0] last_cap [ND];
    int          last_cnt [ND];
    logic        prev_sck [ND];

    always @(negedge clk) begin
        for (int g = 0; g < ND; g++) begin
            logic [11:0] ex, got;
            bit lead;
            ex  = model_out(g, busy[g] && rst_n, cyc - start[g] + 1, mdat[g], msel[g]);
            got = {obs_rdy[g], obs_done[g], obs_sck[g], obs_mosi[g], obs_cs[g]};
            n_cmp++;
            if (got !== ex) begin
                n_bad++;
                $display("FAIL cycle_out dut%0d cyc%0d: got rdy,done,sck,mosi,cs=%b expected %b",
                         g, cyc, got, ex);
            end
            if (obs_done[g]) begin
                last_cap[g] = cap[g];
                last_cnt[g] = capn[g];
            end
            if (&obs_cs[g]) begin
                cap[g] = 0; capn[g] = 0;
            end else if (obs_sck[g] !== prev_sck[g]) begin
                lead = (obs_sck[g] != (cfg_mode(g) >= 2));
                if (lead != ((cfg_mode(g) % 2) == 1)) begin
                    cap[g] = {cap[g][30:0], obs_mosi[g]};
                    capn[g]++;
                end
            end
            prev_sck[g] = obs_sck[g];
        end
    end

    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic start_req(input int g, input logic [31:0] d, input logic [2:0] s, input bit keep);
        drv_dat[g] = d; drv_sel[g] = s; drv_dv[g] = 1'b1;
        @(negedge clk);
        if (!keep) drv_dv[g] = 1'b0;
        cur = 1;
    endtask

    task automatic upto(input int n);
        while (cur < n) begin
            @(negedge clk);
            cur++;
        end
    endtask

    initial begin
        for (int g = 0; g < ND; g++) begin
            cap[g] = 0; capn[g] = 0; last_cap[g] = 0; last_cnt[g] = 0; prev_sck[g] = 1'b0;
        end
        rst_n = 1'b1; drv_dv = '0; drv_dat = '0; drv_sel = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        lit("rst_ready", obs_rdy[0], 1);
        lit("rst_done", obs_done[0], 0);
        lit("rst_cs", obs_cs[2], 8'hFF);
        lit("rst_sck_mode0", obs_sck[0], 0);
        lit("rst_sck_mode3", obs_sck[1], 1);
        lit("rst_mosi", obs_mosi[0], 0);
        rst_n = 1'b1;
        @(negedge clk);

        // A: mode 0, H=2, W=14
        start_req(0, 32'h2A5C, 3'd0, 1'b0);
        lit("A_cs_c1", obs_cs[0], 8'hFE);
        lit("A_mosi_c1", obs_mosi[0], 1);
        upto(2);  lit("A_sck_c2", obs_sck[0], 0);
        upto(3);  lit("A_sck_c3", obs_sck[0], 1);
        upto(58); lit("A_cs_c58", obs_cs[0], 8'hFE);
        upto(59); lit("A_done_c59", obs_done[0], 1); lit("A_cs_c59", obs_cs[0], 8'hFF);
                  lit("A_rdy_c59", obs_rdy[0], 0);
        upto(60); lit("A_rdy_c60", obs_rdy[0], 0);
        upto(61); lit("A_rdy_c61", obs_rdy[0], 1);
                  lit("A_word", last_cap[0], 32'h2A5C); lit("A_bits", last_cnt[0], 14);

        // B: mode 3, H=1
        start_req(1, 32'h2A5C, 3'd0, 1'b0);
        lit("B_sck_c1", obs_sck[1], 1); lit("B_mosi_c1", obs_mosi[1], 0);
        upto(2);  lit("B_sck_c2", obs_sck[1], 0); lit("B_mosi_c2", obs_mosi[1], 1);
        upto(29); lit("B_done_c29", obs_done[1], 0);
        upto(30); lit("B_done_c30", obs_done[1], 1);
        upto(32); lit("B_word", last_cap[1], 32'h2A5C); lit("B_rdy_c32", obs_rdy[1], 1);

        // C: four chip selects, back-to-back with DV held
        start_req(2, 32'h0001, 3'd2, 1'b1);
        lit("C_cs_c1", obs_cs[2], 8'hFB);
        drv_dat[2] = 32'h3FFF; drv_sel[2] = 3'd3;
        upto(58); lit("C_cs_c58", obs_cs[2], 8'hFB);
        upto(59); lit("C_cs_c59", obs_cs[2], 8'hFF);
        upto(61); lit("C_cs_c61", obs_cs[2], 8'hFF); lit("C_rdy_c61", obs_rdy[2], 1);
                  lit("C_word1", last_cap[2], 32'h0001);
        upto(62); lit("C_cs_c62", obs_cs[2], 8'hF7); lit("C_rdy_c62", obs_rdy[2], 0);
        drv_dv[2] = 1'b0;
        upto(122); lit("C_word2", last_cap[2], 32'h3FFF);
        upto(123); lit("C_rdy_end", obs_rdy[2], 1);

        // D1: mode 1 and D2: mode 2, H=3, W=8
        start_req(3, 32'hA5, 3'd0, 1'b0);
        lit("D1_sck_c1", obs_sck[3], 0);
        upto(4);  lit("D1_sck_c4", obs_sck[3], 1); lit("D1_mosi_c4", obs_mosi[3], 1);
        upto(7);  lit("D1_sck_c7", obs_sck[3], 0);
        upto(51); lit("D1_sck_c51", obs_sck[3], 0); lit("D1_cs_c51", obs_cs[3], 8'hFE);
        upto(52); lit("D1_done_c52", obs_done[3], 1);
        upto(54); lit("D1_word", last_cap[3], 32'hA5); lit("D1_bits", last_cnt[3], 8);

        start_req(4, 32'hA5, 3'd0, 1'b0);
        lit("D2_sck_c1", obs_sck[4], 1); lit("D2_mosi_c1", obs_mosi[4], 1);
        upto(4);  lit("D2_sck_c4", obs_sck[4], 0);
        upto(51); lit("D2_sck_c51", obs_sck[4], 1); lit("D2_cs_c51", obs_cs[4], 8'hFE);
        upto(52); lit("D2_done_c52", obs_done[4], 1);
        upto(54); lit("D2_word", last_cap[4], 32'hA5);

        // A: data change and extra request mid-frame are ignored
        start_req(0, 32'h2A5C, 3'd0, 1'b0);
        upto(20);
        drv_dat[0] = 32'h0; drv_dv[0] = 1'b1;
        @(negedge clk); cur++;
        drv_dv[0] = 1'b0;
        upto(61); lit("A2_word", last_cap[0], 32'h2A5C); lit("A2_rdy", obs_rdy[0], 1);

        // A: asynchronous reset mid-frame, then a clean frame
        start_req(0, 32'h3FFF, 3'd0, 1'b0);
        upto(21); lit("A3_cs_pre", obs_cs[0], 8'hFE); lit("A3_mosi_pre", obs_mosi[0], 1);
        #1 rst_n = 1'b0;
        #1;
        lit("A3_rst_rdy", obs_rdy[0], 1); lit("A3_rst_done", obs_done[0], 0);
        lit("A3_rst_sck", obs_sck[0], 0); lit("A3_rst_mosi", obs_mosi[0], 0);
        lit("A3_rst_cs", obs_cs[0], 8'hFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_req(0, 32'h1234, 3'd0, 1'b0);
        upto(61); lit("A4_word", last_cap[0], 32'h1234); lit("A4_bits", last_cnt[0], 14);

        // E: gap 0, out-of-range select, back-to-back
        start_req(5, 32'hB, 3'd5, 1'b1);
        lit("E_cs_c1", obs_cs[5], 8'hFE); lit("E_mosi_c1", obs_mosi[5], 1);
        upto(9);  lit("E_done_c9", obs_done[5], 0); lit("E_rdy_c9", obs_rdy[5], 0);
        upto(10); lit("E_done_c10", obs_done[5], 1); lit("E_rdy_c10", obs_rdy[5], 1);
                  lit("E_cs_c10", obs_cs[5], 8'hFF);
        upto(11); lit("E_cs_c11", obs_cs[5], 8'hFE); lit("E_rdy_c11", obs_rdy[5], 0);
                  lit("E_word", last_cap[5], 32'hB); lit("E_bits", last_cnt[5], 4);
        drv_dv[5] = 1'b0;
        upto(22); lit("E_word2", last_cap[5], 32'hB); lit("E_rdy_end", obs_rdy[5], 1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
